regfile_port_ctrl: RTL and testbench

//  Initiator side of the 2R/1W register-file port (Ra/Rb/Rw/RegWr/busW -> busA/busB).

---
 rtl/regfile_port_ctrl.sv | 156 +++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Initiator-side controller for a 2R/1W register-file port: one command at a time
// in over valid/ready, read/write cycles sequenced, result out over valid/ready.
// Optional macro REGCTRL_ZERO_GUARD_EN suppresses writes to register index 0.
module regfile_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_ra,
    input  logic [ADDR_WIDTH-1:0] cmd_rb,
    input  logic [ADDR_WIDTH-1:0] cmd_rw,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_a,
    output logic [DATA_WIDTH-1:0] rsp_b,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] Ra,
    output logic [ADDR_WIDTH-1:0] Rb,
    output logic [ADDR_WIDTH-1:0] Rw,
    output logic                  RegWr,
    output logic [DATA_WIDTH-1:0] busW,
    input  logic [DATA_WIDTH-1:0] busA,
    input  logic [DATA_WIDTH-1:0] busB
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_COPY  = 2'b11
    } op_t;

    state_t                  state;
    state_t                  state_next;
    op_t                     lat_op;
    logic [ADDR_WIDTH-1:0]   lat_rw;
    logic                    accept;
    logic                    zero_block;
    logic [DATA_WIDTH-1:0]   sum;

    assign accept = cmd_valid && cmd_ready;
    assign sum    = busA + busB;  // carry out intentionally dropped

`ifdef REGCTRL_ZERO_GUARD_EN
    assign zero_block = (lat_rw == '0);
`else
    assign zero_block = 1'b0;
`endif

    // Combinational outputs follow the state register, so an async reset drops them at once.
    assign cmd_ready = (state == ST_IDLE) && !sys_rst;
    assign rsp_valid = (state == ST_RESP);
    assign RegWr     = (state == ST_WR) && !zero_block;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (op_t'(cmd_op) == OP_WRITE) ? ST_WR : ST_RD;
                end
            end
            ST_RD:   state_next = (lat_op == OP_READ) ? ST_RESP : ST_WR;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: command latch, read capture and response registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lat_op  <= OP_READ;
            lat_rw  <= '0;
            Ra      <= '0;
            Rb      <= '0;
            Rw      <= '0;
            busW    <= '0;
            rsp_a   <= '0;
            rsp_b   <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op  <= op_t'(cmd_op);
                        lat_rw  <= cmd_rw;
                        rsp_err <= 1'b0;
                        if (op_t'(cmd_op) == OP_WRITE) begin
                            Rw    <= cmd_rw;
                            busW  <= cmd_data;
                            rsp_a <= cmd_data;
                            rsp_b <= '0;
                        end else begin
                            Ra <= cmd_ra;
                            Rb <= cmd_rb;
                        end
                    end
                end
                ST_RD: begin
                    // Reads complete here, before WR, so ra==rw / rb==rw hazards resolve correctly.
                    case (lat_op)
                        OP_ADD: begin
                            Rw    <= lat_rw;
                            busW  <= sum;
                            rsp_a <= sum;
                            rsp_b <= busB;
                        end
                        OP_COPY: begin
                            Rw    <= lat_rw;
                            busW  <= busA;
                            rsp_a <= busA;
                            rsp_b <= '0;
                        end
                        default: begin
                            rsp_a <= busA;
                            rsp_b <= busB;
                        end
                    endcase
                end
                ST_WR: begin
                    rsp_err <= zero_block;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed self-checking bench for regfile_port_ctrl with a behavioural register file.
// Honours REGCTRL_ZERO_GUARD_EN when choosing the expected index-0 write behaviour.
module tb_regfile_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGCTRL_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          sys_clk;
    logic          sys_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [AW-1:0] cmd_rw;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;
    logic          rsp_err;
    logic [AW-1:0] Ra;
    logic [AW-1:0] Rb;
    logic [AW-1:0] Rw;
    logic          RegWr;
    logic [DW-1:0] busW;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;

    logic [DW-1:0] rf [2**AW];
    int            pulses;
    logic [DW-1:0] last_busw;
    int            n_tests;
    int            n_fail;

    regfile_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_err(rsp_err), .Ra(Ra), .Rb(Rb), .Rw(Rw), .RegWr(RegWr), .busW(busW),
        .busA(busA), .busB(busB)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Register file: combinational reads, write on rising edge.
    assign busA = rf[Ra];
    assign busB = rf[Rb];
    always @(posedge sys_clk) begin
        if (RegWr === 1'b1) begin
            rf[Rw]    <= busW;
            pulses    <= pulses + 1;
            last_busw <= busW;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command from an IDLE, just-after-edge point; returns just after the
    // response handshake edge. 'hold' cycles of rsp_ready low are applied first.
    task automatic do_cmd(input string tag, input logic [1:0] op,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                          input logic [AW-1:0] rw, input logic [DW-1:0] data,
                          input int exp_lat, input logic [DW-1:0] exp_a,
                          input logic [DW-1:0] exp_b, input logic exp_err,
                          input int exp_pulses, input int hold);
        int n;
        int p0;
        p0 = pulses;
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rw    = rw;
        cmd_data  = data;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " rsp_a"}, 64'(rsp_a), 64'(exp_a));
        check({tag, " rsp_b"}, 64'(rsp_b), 64'(exp_b));
        check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge sys_clk);
            #1;
            check({tag, " hold rsp_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, " hold rsp_a"}, 64'(rsp_a), 64'(exp_a));
            check({tag, " hold rsp_b"}, 64'(rsp_b), 64'(exp_b));
            check({tag, " hold cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid done"}, 64'(rsp_valid), 64'd0);
        check({tag, " RegWr pulses"}, 64'(pulses - p0), 64'(exp_pulses));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pulses    = 0;
        last_busw = '0;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rw    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst RegWr", 64'(RegWr), 64'd0);
        check("rst Ra", 64'(Ra), 64'd0);
        check("rst Rw", 64'(Rw), 64'd0);
        check("rst busW", 64'(busW), 64'd0);
        check("rst rsp_a", 64'(rsp_a), 64'd0);
        check("rst rsp_err", 64'(rsp_err), 64'd0);
        sys_rst = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        check("idle cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle no RegWr", 64'(pulses), 64'd0);

        // WRITE / READ basics: ops 00 READ, 01 WRITE, 10 ADD, 11 COPY
        do_cmd("wr r2", 2'b01, 5'd0, 5'd0, 5'd2, 32'd7, 2, 32'd7, 32'd0, 1'b0, 1, 0);
        do_cmd("wr r1", 2'b01, 5'd0, 5'd0, 5'd1, 32'd20, 2, 32'd20, 32'd0, 1'b0, 1, 0);
        do_cmd("rd r1 r2", 2'b00, 5'd1, 5'd2, 5'd0, 32'd0, 2, 32'd20, 32'd7, 1'b0, 0, 0);

        // ADD with carry dropped
        do_cmd("wr r1 max", 2'b01, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
        do_cmd("wr r2 two", 2'b01, 5'd0, 5'd0, 5'd2, 32'd2, 2, 32'd2, 32'd0, 1'b0, 1, 0);
        do_cmd("add r3", 2'b10, 5'd1, 5'd2, 5'd3, 32'd0, 3, 32'd1, 32'd2, 1'b0, 1, 0);
        check("add busW", 64'(last_busw), 64'd1);
        do_cmd("rd r3", 2'b00, 5'd3, 5'd3, 5'd0, 32'd0, 2, 32'd1, 32'd1, 1'b0, 0, 0);

        // Read-before-write hazard: r1 <- r1 + r1
        do_cmd("add r1 self", 2'b10, 5'd1, 5'd1, 5'd1, 32'd0, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1, 0);
        do_cmd("rd r1 self", 2'b00, 5'd1, 5'd2, 5'd0, 32'd0, 2, 32'hFFFF_FFFE, 32'd2, 1'b0, 0, 0);

        // COPY
        do_cmd("copy r6", 2'b11, 5'd3, 5'd9, 5'd6, 32'd0, 3, 32'd1, 32'd0, 1'b0, 1, 0);
        do_cmd("rd r6", 2'b00, 5'd6, 5'd3, 5'd0, 32'd0, 2, 32'd1, 32'd1, 1'b0, 0, 0);

        // Backpressure: rsp_ready low for 10 cycles
        do_cmd("rd hold", 2'b00, 5'd2, 5'd3, 5'd0, 32'd0, 2, 32'd2, 32'd1, 1'b0, 0, 10);

        // Reset asserted during WR of COPY r5 <- r4
        do_cmd("wr r4", 2'b01, 5'd0, 5'd0, 5'd4, 32'h44, 2, 32'h44, 32'd0, 1'b0, 1, 0);
        do_cmd("wr r5", 2'b01, 5'd0, 5'd0, 5'd5, 32'h55, 2, 32'h55, 32'd0, 1'b0, 1, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_ra    = 5'd4;
        cmd_rb    = 5'd0;
        cmd_rw    = 5'd5;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        check("copy WR RegWr", 64'(RegWr), 64'd1);
        check("copy WR Rw", 64'(Rw), 64'd5);
        sys_rst = 1'b1;
        #1;
        check("midrst RegWr", 64'(RegWr), 64'd0);
        check("midrst cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst rsp_valid", 64'(rsp_valid), 64'd0);
        #1;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("postrst cmd_ready", 64'(cmd_ready), 64'd1);
        check("postrst rsp_valid", 64'(rsp_valid), 64'd0);
        do_cmd("rd r5 kept", 2'b00, 5'd5, 5'd4, 5'd0, 32'd0, 2, 32'h55, 32'h44, 1'b0, 0, 0);

        // Index-0 write: suppressed only with the guard build
        check("r0 cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_rw    = 5'd0;
        cmd_data  = 32'd9;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        check("r0 WR RegWr", 64'(RegWr), 64'(!GUARD));
        @(posedge sys_clk);
        #1;
        check("r0 rsp_valid", 64'(rsp_valid), 64'd1);
        check("r0 rsp_a", 64'(rsp_a), 64'd9);
        check("r0 rsp_err", 64'(rsp_err), 64'(GUARD));
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b0;
        check("r0 done", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
